alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
Multi-cycle, parametrised successor to the 4-bit nibble ALU. It computes a WIDTH-bit ALU operation by processing one DIGIT_W-bit digit per clock, LSB digit first, chaining carry/borrow between digits. It adds N (subtract) and H (half-carry) flags and a start/busy/done handshake. It sits in the CPU datapath for 8-bit and 16-bit arithmetic, and reuses the same 3-bit op encoding as the nibble ALU.

Parameters:
WIDTH, 8, operand/result width in bits; must be an integer multiple of DIGIT_W.
DIGIT_W, 4, bits processed per cycle; NUM_DIGITS = WIDTH/DIGIT_W must be >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
alu_op  input  3  0 add, 1 adc, 2 sub, 3 sbc, 4 and, 5 xor, 6 or, 7 cp (compare)
in_A  input  WIDTH  operand A, latched on accepted start
in_B  input  WIDTH  operand B, latched on accepted start
in_C  input  1  carry/borrow in for adc/sbc, latched on accepted start
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse when results become valid
out  output  WIDTH  result, held from done until the next accepted start
out_Z  output  1  zero flag
out_N  output  1  subtract flag
out_H  output  1  half-carry/borrow flag
out_C  output  1  carry/borrow flag

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy=0, done=0, out=0, all flags 0; digit counter=0; internal operand and carry registers cleared. Reset overrides everything, including start in the same cycle. Reset during RUN aborts the operation with no done pulse.
- States: IDLE, RUN. There is no separate DONE state; done is a registered pulse.
- IDLE, start=1: latch alu_op, in_A, in_B and carry-in, then go to RUN. busy=1 and done=0 from the next cycle. Carry-in is in_C for adc/sbc and 0 for all other ops.
- IDLE, start=0: hold state and outputs; done=0.
- RUN: each edge processes digit k (k = 0 .. NUM_DIGITS-1) using a DIGIT_W+1-bit add or subtract with the chained carry.
  - add/adc: A_k + B_k + c.
  - sub/sbc/cp: A_k - B_k - c; the carry register holds borrow (1 = borrow).
  - Logic ops: bitwise per digit; no chaining.
- Result digits shift into the result register MSB-first, so after the last digit the register holds bits [WIDTH-1:0] in order.
- out_H captures the carry/borrow out of digit 0 on the edge that processes digit 0. For WIDTH=8, DIGIT_W=4 this is the nibble carry.
- On the edge processing digit NUM_DIGITS-1: go to IDLE; busy=0, done=1 for exactly one cycle. out and all flags update on this same edge.
- Latency: done is high in the cycle NUM_DIGITS+1 cycles after the start cycle. For the default, start in cycle t gives done in t+3.
- Flags:
  - out_C: final carry/borrow for add/adc/sub/sbc/cp; 0 for logic ops.
  - out_N: 1 for sub/sbc/cp, else 0.
  - out_H: digit-0 carry/borrow for arithmetic ops; 1 for and; 0 for xor/or.
  - out_Z: 1 when the full WIDTH-bit computed value is 0. For cp this is the subtraction value.
- cp: out = latched in_A (unchanged); flags are computed as for sub.
- Intermediate values: out and flags do not change while busy=1. The previous result stays visible until completion.
- start while busy=1: ignored, with no queuing.
- start in the done cycle: accepted, because busy=0 in that cycle. The next RUN begins and out/flags hold the completed values until the new completion.
- Input changes after the start edge have no effect on the operation in flight.

Test Plan:
- Default params, add A=0x3A, B=0xC6 -> done at start+3, out=0x00, Z=1, N=0, H=1, C=1; busy high for exactly 2 cycles.
- sub 0x10-0x01 -> out=0x0F, Z=0, N=1, H=1, C=0. Then sbc 0x00-0x00 with in_C=1 -> out=0xFF, N=1, H=1, C=1, Z=0.
- and 0xF0&0x0F -> out=0x00, Z=1, H=1, C=0. or 0xA0|0x05 -> out=0xA5, Z=0, H=0. cp A=0x42, B=0x42 -> out=0x42, Z=1, N=1, C=0.
- Start add 0x01+0x01, then pulse start with sub 0xFF-0x00 while busy -> the second start is ignored: one done, out=0x02. Back-to-back start in the done cycle -> accepted, second done 3 cycles later.
- Assert rst during the RUN cycle of an adc -> next cycle busy=0, done=0, out=0, flags 0; no done ever pulses for the aborted op.
- WIDTH=16, DIGIT_W=4: add 0xFFFF+0x0001 -> done at start+5, out=0x0000, Z=1, H=1, C=1. adc 0x1234+0x4321 with in_C=1 -> out=0x5556, C=0, H=0.

Source files
------------

// File: rtl/alu_serial.sv
// Digit-serial ALU: one DIGIT_W-bit digit per clock, LSB digit first, with
// chained carry/borrow, N/H/Z/C flags and a start/busy/done handshake.
`timescale 1ns/1ps

module alu_serial #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             out_Z,
    output logic             out_N,
    output logic             out_H,
    output logic             out_C
);

    localparam int unsigned NUM_DIGITS = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SUM_W      = DIGIT_W + 1;
    localparam int unsigned RES_W      = WIDTH - DIGIT_W;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_nx_state;
    logic [2:0]         r_op, w_nx_op;
    logic [WIDTH-1:0]   r_a, w_nx_a;
    logic [WIDTH-1:0]   r_b, w_nx_b;
    logic               r_cy, w_nx_cy;
    logic [CNT_W-1:0]   r_cnt, w_nx_cnt;
    logic [RES_W-1:0]   r_res, w_nx_res;
    logic               r_dig0_cy, w_nx_dig0_cy;
    logic               r_busy, w_nx_busy;
    logic               r_done, w_nx_done;
    logic [WIDTH-1:0]   r_out, w_nx_out;
    logic               r_z, w_nx_z;
    logic               r_n, w_nx_n;
    logic               r_h, w_nx_h;
    logic               r_c, w_nx_c;

    logic [DIGIT_W-1:0] w_a_dig;
    logic [DIGIT_W-1:0] w_b_dig;
    logic [SUM_W-1:0]   w_add;
    logic [SUM_W-1:0]   w_sub;
    logic [DIGIT_W-1:0] w_dig_res;
    logic               w_dig_cy;
    logic [WIDTH-1:0]   w_res_full;
    logic               w_is_sub;
    logic               w_is_arith;
    logic               w_last;

    // Current digit of each operand, selected by the digit counter
    assign w_a_dig = DIGIT_W'(r_a >> (DIGIT_W * 32'(r_cnt)));
    assign w_b_dig = DIGIT_W'(r_b >> (DIGIT_W * 32'(r_cnt)));

    // Bit DIGIT_W of the subtract wraps to 1 exactly when a borrow occurs
    assign w_add = {1'b0, w_a_dig} + {1'b0, w_b_dig} + SUM_W'(r_cy);
    assign w_sub = {1'b0, w_a_dig} - {1'b0, w_b_dig} - SUM_W'(r_cy);

    assign w_is_sub   = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CP);
    assign w_is_arith = !((r_op == OP_AND) || (r_op == OP_XOR) || (r_op == OP_OR));
    assign w_last     = (r_cnt == LAST_DIGIT);

    always_comb begin
        w_dig_res = '0;
        w_dig_cy  = 1'b0;
        unique case (r_op)
            OP_ADD, OP_ADC: begin
                w_dig_res = w_add[DIGIT_W-1:0];
                w_dig_cy  = w_add[DIGIT_W];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                w_dig_res = w_sub[DIGIT_W-1:0];
                w_dig_cy  = w_sub[DIGIT_W];
            end
            OP_AND:  w_dig_res = w_a_dig & w_b_dig;
            OP_XOR:  w_dig_res = w_a_dig ^ w_b_dig;
            OP_OR:   w_dig_res = w_a_dig | w_b_dig;
            default: w_dig_res = '0;
        endcase
    end

    // Full computed value once the final digit lands on top of the shifted digits
    assign w_res_full = {w_dig_res, r_res};

    always_comb begin
        w_nx_state   = r_state;
        w_nx_op      = r_op;
        w_nx_a       = r_a;
        w_nx_b       = r_b;
        w_nx_cy      = r_cy;
        w_nx_cnt     = r_cnt;
        w_nx_res     = r_res;
        w_nx_dig0_cy = r_dig0_cy;
        w_nx_busy    = r_busy;
        w_nx_done    = 1'b0;
        w_nx_out     = r_out;
        w_nx_z       = r_z;
        w_nx_n       = r_n;
        w_nx_h       = r_h;
        w_nx_c       = r_c;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nx_state = S_RUN;
                    w_nx_busy  = 1'b1;
                    w_nx_op    = alu_op;
                    w_nx_a     = in_A;
                    w_nx_b     = in_B;
                    w_nx_cy    = ((alu_op == OP_ADC) || (alu_op == OP_SBC)) ? in_C : 1'b0;
                    w_nx_cnt   = '0;
                end
            end
            S_RUN: begin
                w_nx_cy  = w_dig_cy;
                w_nx_res = w_res_full[WIDTH-1:DIGIT_W];
                w_nx_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == '0) begin
                    w_nx_dig0_cy = w_dig_cy;
                end
                if (w_last) begin
                    w_nx_state = S_IDLE;
                    w_nx_busy  = 1'b0;
                    w_nx_done  = 1'b1;
                    w_nx_out   = (r_op == OP_CP) ? r_a : w_res_full;
                    w_nx_z     = (w_res_full == '0);
                    w_nx_n     = w_is_sub;
                    w_nx_c     = w_is_arith ? w_dig_cy : 1'b0;
                    w_nx_h     = w_is_arith ? r_dig0_cy : (r_op == OP_AND);
                end
            end
            default: w_nx_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cy      <= 1'b0;
            r_cnt     <= '0;
            r_res     <= '0;
            r_dig0_cy <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_out     <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_h       <= 1'b0;
            r_c       <= 1'b0;
        end else begin
            r_state   <= w_nx_state;
            r_op      <= w_nx_op;
            r_a       <= w_nx_a;
            r_b       <= w_nx_b;
            r_cy      <= w_nx_cy;
            r_cnt     <= w_nx_cnt;
            r_res     <= w_nx_res;
            r_dig0_cy <= w_nx_dig0_cy;
            r_busy    <= w_nx_busy;
            r_done    <= w_nx_done;
            r_out     <= w_nx_out;
            r_z       <= w_nx_z;
            r_n       <= w_nx_n;
            r_h       <= w_nx_h;
            r_c       <= w_nx_c;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign out   = r_out;
    assign out_Z = r_z;
    assign out_N = r_n;
    assign out_H = r_h;
    assign out_C = r_c;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: 8-bit default instance plus a 16-bit instance.
`timescale 1ns/1ps

module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst;

    logic        st8, c8, busy8, done8, z8, n8, h8, cf8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, out8;

    logic        st16, c16, busy16, done16, z16, n16, h16, cf16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, out16;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_serial u8 (
        .clk(clk), .rst(rst), .start(st8), .alu_op(op8),
        .in_A(a8), .in_B(b8), .in_C(c8),
        .busy(busy8), .done(done8), .out(out8),
        .out_Z(z8), .out_N(n8), .out_H(h8), .out_C(cf8)
    );

    alu_serial #(.WIDTH(16), .DIGIT_W(4)) u16 (
        .clk(clk), .rst(rst), .start(st16), .alu_op(op16),
        .in_A(a16), .in_B(b16), .in_C(c16),
        .busy(busy16), .done(done16), .out(out16),
        .out_Z(z16), .out_N(n16), .out_H(h16), .out_C(cf16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts an 8-bit op and returns positioned in the expected done cycle
    task automatic go8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
        op8 = op; a8 = a; b8 = b; c8 = c; st8 = 1'b1;
        tick;
        st8 = 1'b0;
        tick;
        tick;
    endtask

    task automatic res8(input string tag, input logic [7:0] eo, input logic ez, input logic en,
                        input logic eh, input logic ec);
        chk({tag, "_done"}, 32'(done8), 32'd1);
        chk({tag, "_busy"}, 32'(busy8), 32'd0);
        chk({tag, "_out"},  32'(out8),  32'(eo));
        chk({tag, "_Z"},    32'(z8),    32'(ez));
        chk({tag, "_N"},    32'(n8),    32'(en));
        chk({tag, "_H"},    32'(h8),    32'(eh));
        chk({tag, "_C"},    32'(cf8),   32'(ec));
    endtask

    initial begin
        rst = 1'b1;
        st8 = 1'b0; op8 = 3'd0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        st16 = 1'b0; op16 = 3'd0; a16 = 16'h0000; b16 = 16'h0000; c16 = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_out",  32'(out8),  32'd0);
        chk("rst_flags", {28'd0, z8, n8, h8, cf8}, 32'd0);
        chk("rst16_out", 32'(out16), 32'd0);

        // add 0x3A + 0xC6 with cycle-by-cycle handshake checks
        op8 = 3'd0; a8 = 8'h3A; b8 = 8'hC6; c8 = 1'b0; st8 = 1'b1;
        tick;
        chk("add_t1_busy", 32'(busy8), 32'd1);
        chk("add_t1_done", 32'(done8), 32'd0);
        st8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        tick;
        chk("add_t2_busy", 32'(busy8), 32'd1);
        chk("add_t2_done", 32'(done8), 32'd0);
        chk("add_t2_out",  32'(out8),  32'd0);
        tick;
        res8("add", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        tick;
        chk("add_t4_done", 32'(done8), 32'd0);
        chk("add_t4_out",  32'(out8),  32'h00);
        chk("add_t4_C",    32'(cf8),   32'd1);

        go8(3'd2, 8'h10, 8'h01, 1'b1);
        res8("sub", 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        go8(3'd3, 8'h00, 8'h00, 1'b1);
        res8("sbc", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        tick;
        go8(3'd4, 8'hF0, 8'h0F, 1'b1);
        res8("and", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        tick;
        go8(3'd6, 8'hA0, 8'h05, 1'b0);
        res8("or", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        go8(3'd7, 8'h42, 8'h42, 1'b0);
        res8("cp", 8'h42, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        go8(3'd7, 8'h10, 8'h20, 1'b0);
        res8("cp_lt", 8'h10, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;

        // start while busy is ignored
        op8 = 3'd0; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; st8 = 1'b1;
        tick;
        op8 = 3'd2; a8 = 8'hFF; b8 = 8'h00;
        tick;
        chk("ign_t2_busy", 32'(busy8), 32'd1);
        st8 = 1'b0;
        tick;
        res8("ign", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("ign_no_done", 32'(done8), 32'd0);
            chk("ign_idle",    32'(busy8), 32'd0);
        end

        // back-to-back: start accepted in the done cycle
        go8(3'd6, 8'hA0, 8'h05, 1'b0);
        res8("b2b_first", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        op8 = 3'd5; a8 = 8'h3C; b8 = 8'h0F; st8 = 1'b1;
        tick;
        st8 = 1'b0;
        chk("b2b_t1_busy", 32'(busy8), 32'd1);
        chk("b2b_t1_done", 32'(done8), 32'd0);
        chk("b2b_t1_out",  32'(out8),  32'hA5);
        tick;
        chk("b2b_t2_out",  32'(out8),  32'hA5);
        tick;
        res8("b2b_xor", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset during RUN aborts the adc
        op8 = 3'd1; a8 = 8'hFF; b8 = 8'h22; c8 = 1'b1; st8 = 1'b1;
        tick;
        st8 = 1'b0;
        chk("abort_busy_pre", 32'(busy8), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy",  32'(busy8), 32'd0);
        chk("abort_done",  32'(done8), 32'd0);
        chk("abort_out",   32'(out8),  32'd0);
        chk("abort_flags", {28'd0, z8, n8, h8, cf8}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("abort_no_done", 32'(done8), 32'd0);
        end

        // 16-bit instance: add 0xFFFF + 0x0001, done at start+5
        op16 = 3'd0; a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0; st16 = 1'b1;
        tick;
        st16 = 1'b0;
        tick;
        tick;
        tick;
        chk("w16_t4_busy", 32'(busy16), 32'd1);
        chk("w16_t4_done", 32'(done16), 32'd0);
        tick;
        chk("w16_add_done", 32'(done16), 32'd1);
        chk("w16_add_out",  32'(out16),  32'h0000);
        chk("w16_add_flags", {28'd0, z16, n16, h16, cf16}, 32'b1011);
        tick;

        // 16-bit adc 0x1234 + 0x4321 + 1
        op16 = 3'd1; a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b1; st16 = 1'b1;
        tick;
        st16 = 1'b0;
        tick;
        tick;
        tick;
        tick;
        chk("w16_adc_done", 32'(done16), 32'd1);
        chk("w16_adc_out",  32'(out16),  32'h5556);
        chk("w16_adc_flags", {28'd0, z16, n16, h16, cf16}, 32'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
